// File: rtl/board_int_ctrl_if.sv
// board_int_ctrl_if: register-window bus between the core's data-memory port and the interrupt controller.
interface board_int_ctrl_if;
  logic        i_cs;
  logic [4:0]  i_addr;
  logic        i_we;
  logic        i_re;
  logic [3:0]  i_sel;
  logic [31:0] i_wdata;
  logic [31:0] o_rdata;
  modport master (output i_cs, i_addr, i_we, i_re, i_sel, i_wdata, input o_rdata);
  modport slave (input i_cs, i_addr, i_we, i_re, i_sel, i_wdata, output o_rdata);
endinterface

// File: rtl/board_int_ctrl.sv
// board_int_ctrl: masked edge/level interrupt controller with claim register and lowest-index priority.
// Define INT_CTRL_SYNC_EN for a two-flop synchroniser per source; otherwise inputs are registered once.
module board_int_ctrl #(
  parameter int NUM_SRC = 8,
  parameter int ID_W = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] i_irq,
  board_int_ctrl_if.slave    bus,
  output logic               o_int,
  output logic [ID_W-1:0]    o_int_id
);
  localparam int N = NUM_SRC;
  logic [N-1:0] s, p, pend_q, mask, mode, pending, active, lowest, wm, wd, w1c, clr, rise;
  logic [ID_W-1:0] id;
  logic [2:0] word;
  logic wr, claim, unused;
`ifdef INT_CTRL_SYNC_EN
  logic [N-1:0] meta;
`endif
  assign word = bus.i_addr[4:2];
  assign wr = bus.i_cs & bus.i_we;
  assign wd = bus.i_wdata[N-1:0];
  assign unused = ^{bus.i_addr[1:0], bus.i_wdata, bus.i_sel};
  always_comb begin
    wm = '0;
    for (int i = 0; i < N; i++) wm[i] = bus.i_sel[i/8];
  end
  assign rise = s & ~p;
  // Level sources bypass storage and show the synchronised line directly.
  assign pending = (mode & pend_q) | (~mode & s);
  assign active = pending & mask;
  assign lowest = active & (~active + N'(1));
  always_comb begin
    id = '0;
    for (int i = N - 1; i >= 0; i--) if (active[i]) id = ID_W'(i + 1);
  end
  assign claim = bus.i_cs & bus.i_re & (word == 3'd4) & (id != '0);
  assign w1c = (wr && word == 3'd0) ? wd & wm : '0;
  assign clr = w1c | (claim ? lowest : '0);
  assign bus.o_rdata = word == 3'd0 ? 32'(pending) :
                       word == 3'd1 ? 32'(mask) :
                       word == 3'd2 ? 32'(mode) :
                       word == 3'd3 ? 32'(s) :
                       word == 3'd4 ? 32'(id) : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
`ifdef INT_CTRL_SYNC_EN
      meta <= '0;
`endif
      s <= '0;
      p <= '0;
      pend_q <= '0;
      mask <= '0;
      mode <= '0;
      o_int <= 1'b0;
      o_int_id <= '0;
    end else begin
`ifdef INT_CTRL_SYNC_EN
      meta <= i_irq;
      s <= meta;
`else
      s <= i_irq;
`endif
      p <= s;
      // A new rising edge wins over a simultaneous clear.
      pend_q <= mode & (rise | (pend_q & ~clr));
      mask <= (wr && word == 3'd1) ? (mask & ~wm) | (wd & wm) : mask;
      mode <= (wr && word == 3'd2) ? (mode & ~wm) | (wd & wm) : mode;
      o_int <= |active;
      o_int_id <= id;
    end
  end
endmodule

// File: tb/tb_board_int_ctrl.sv
// tb_board_int_ctrl: directed checks of register map, edge/level latching, priority, claim and latency.
module tb_board_int_ctrl;
`ifdef INT_CTRL_SYNC_EN
  localparam int S = 2;
`else
  localparam int S = 1;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] irq = '0;
  logic o_int;
  logic [5:0] o_int_id;
  logic [31:0] rv;
  int checks = 0;
  int errors = 0;
  board_int_ctrl_if bus();
  board_int_ctrl #(.NUM_SRC(8), .ID_W(6)) dut (
    .clk(clk), .reset(reset), .i_irq(irq), .bus(bus), .o_int(o_int), .o_int_id(o_int_id)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input int w, input logic [31:0] d, input logic [3:0] sel);
    bus.i_cs = 1'b1; bus.i_we = 1'b1; bus.i_addr = 5'(w * 4); bus.i_wdata = d; bus.i_sel = sel;
    tick();
    bus.i_cs = 1'b0; bus.i_we = 1'b0; bus.i_wdata = '0; bus.i_sel = '0;
  endtask
  task automatic rd(input int w, output logic [31:0] d);
    bus.i_cs = 1'b1; bus.i_addr = 5'(w * 4);
    #1 d = bus.o_rdata;
    bus.i_cs = 1'b0;
  endtask
  task automatic do_claim();
    bus.i_cs = 1'b1; bus.i_re = 1'b1; bus.i_addr = 5'd16;
    tick();
    bus.i_cs = 1'b0; bus.i_re = 1'b0;
  endtask
  initial begin
    bus.i_cs = 0; bus.i_addr = 0; bus.i_we = 0; bus.i_re = 0; bus.i_sel = 0; bus.i_wdata = 0;
    repeat (2) tick();
    reset = 1'b0;
    for (int w = 0; w < 8; w++) begin
      rd(w, rv);
      chk($sformatf("reset_rd%0d", w), rv, 32'h0);
    end
    chk("reset_int", 32'(o_int), 32'h0);
    chk("reset_id", 32'(o_int_id), 32'h0);
    // Edge source 0 pulse, latency and claim
    wr(1, 32'hFF, 4'hF);
    wr(2, 32'h01, 4'hF);
    irq[0] = 1'b1; tick(); irq[0] = 1'b0;
    repeat (S) tick();
    rd(0, rv); chk("edge_pend", rv, 32'h1);
    chk("edge_int_early", 32'(o_int), 32'h0);
    tick();
    chk("edge_int", 32'(o_int), 32'h1);
    chk("edge_id", 32'(o_int_id), 32'h1);
    rd(4, rv); chk("claim_val", rv, 32'h1);
    do_claim();
    rd(0, rv); chk("claim_clr", rv, 32'h0);
    chk("claim_int_hold", 32'(o_int), 32'h1);
    tick();
    chk("claim_int_drop", 32'(o_int), 32'h0);
    // Level sources 2/3 and priority
    wr(2, 32'h0, 4'hF);
    wr(1, 32'h0C, 4'hF);
    irq = 8'h0C;
    repeat (S + 1) tick();
    chk("lvl_int", 32'(o_int), 32'h1);
    chk("lvl_id3", 32'(o_int_id), 32'h3);
    rd(0, rv); chk("lvl_pend", rv, 32'h0C);
    wr(0, 32'hFF, 4'hF);
    rd(0, rv); chk("lvl_w1c", rv, 32'h0C);
    irq = 8'h08;
    repeat (S + 1) tick();
    chk("lvl_id4", 32'(o_int_id), 32'h4);
    irq = 8'h00;
    repeat (S + 1) tick();
    chk("lvl_id0", 32'(o_int_id), 32'h0);
    chk("lvl_int0", 32'(o_int), 32'h0);
    // Masked edge source 5 still latches
    wr(1, 32'h0, 4'hF);
    wr(2, 32'h20, 4'hF);
    irq = 8'h20; tick(); irq = 8'h00;
    repeat (S + 1) tick();
    rd(0, rv); chk("mask_pend", rv, 32'h20);
    chk("mask_int0", 32'(o_int), 32'h0);
    wr(1, 32'h20, 4'hF);
    chk("unmask_int_early", 32'(o_int), 32'h0);
    tick();
    chk("unmask_int", 32'(o_int), 32'h1);
    chk("unmask_id", 32'(o_int_id), 32'h6);
    // W1C colliding with a new edge on source 1
    wr(0, 32'h20, 4'hF);
    wr(2, 32'h02, 4'hF);
    wr(1, 32'h02, 4'hF);
    irq = 8'h02; tick(); irq = 8'h00;
    repeat (S + 1) tick();
    rd(0, rv); chk("src1_pend", rv, 32'h02);
    irq = 8'h02;
    repeat (S) tick();
    wr(0, 32'h02, 4'hF);
    rd(0, rv); chk("w1c_vs_rise", rv, 32'h02);
    wr(0, 32'h02, 4'hF);
    rd(0, rv); chk("w1c_alone", rv, 32'h0);
    irq = 8'h00;
    // Byte enables, unused offsets, read-only RAW
    wr(1, 32'h0, 4'hF);
    wr(1, 32'hFFFF_FFFF, 4'b1110);
    rd(1, rv); chk("sel_upper", rv, 32'h0);
    wr(1, 32'hFFFF_FFFF, 4'b0001);
    rd(1, rv); chk("sel_low", rv, 32'hFF);
    wr(2, 32'hFFFF_FFFF, 4'hF);
    rd(2, rv); chk("mode_trunc", rv, 32'hFF);
    wr(5, 32'hFFFF_FFFF, 4'hF);
    rd(5, rv); chk("off5", rv, 32'h0);
    wr(2, 32'h0, 4'hF);
    irq = 8'hA4;
    repeat (S) tick();
    rd(3, rv); chk("raw", rv, 32'hA4);
    wr(3, 32'h0, 4'hF);
    rd(3, rv); chk("raw_ro", rv, 32'hA4);
    rd(4, rv); chk("claim_lvl", rv, 32'h3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/board_int_ctrl.md
# board_int_ctrl

Parametrised interrupt controller for the board level. It takes `NUM_SRC` external interrupt lines, synchronises them and detects edges or levels per source. Each source is masked and latched as pending, and the block raises a single registered request with a priority-encoded source ID to the core. Software reaches it through a memory-mapped register window on the core's data-memory bus, alongside DMEM.

## Interface
- `NUM_SRC`, 8: number of interrupt sources, 1..32.
- `ID_W`, 6: width of claim ID field; must hold `NUM_SRC`.
- `clk`  in  1  board clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `i_irq`  in  `NUM_SRC`  raw asynchronous interrupt lines; bit n = source n.
- `i_cs`  in  1  register window selected (address decode done by board).
- `i_addr`  in  5  byte offset within window; bits [4:2] select the word.
- `i_we`  in  1  write strobe, valid with `i_cs`.
- `i_re`  in  1  read strobe, valid with `i_cs`; only needed for the claim side effect.
- `i_sel`  in  4  byte write enables, bit k covers `wdata[8k+7:8k]`.
- `i_wdata`  in  32  write data.
- `o_rdata`  out  32  read data, combinational from `i_addr` and current state.
- `o_int`  out  1  registered request to the core's interrupt input.
- `o_int_id`  out  `ID_W`  registered; highest-priority source + 1, 0 when none.

## Operation
- Register map (word offset):
  - 0 PENDING: R; W1C per bit, edge-mode sources only.
  - 1 MASK: RW, 1 = enabled.
  - 2 MODE: RW, 1 = rising-edge, 0 = level.
  - 3 RAW: R; synchronised input levels.
  - 4 CLAIM: R.
  - Offsets 5–7: read 0, writes ignored.
- Register bits at or above `NUM_SRC` read 0 and ignore writes.
- Writes honour `i_sel` per byte. Writes take effect only when `i_cs && i_we`.
- Synchroniser output `s[n]`, previous value `p[n]`.
- Edge mode:
  - `pending[n]` is set when `s[n] & ~p[n]`.
  - `pending[n]` is cleared by a W1C write or by a claim.
  - Set and clear in the same cycle: set wins.
- Level mode:
  - `pending[n]` reads as `s[n]` directly, with no storage.
  - W1C and claim have no effect.
- Active vector is `pending & mask`. Priority goes to the lowest index.
- CLAIM reads `{zeros, id}`, where `id` = lowest active index + 1, or 0 when none.
- Claim side effect: `i_cs && i_re && word==4 && id!=0` clears that source's pending bit at the edge, if the source is edge-mode.
- MASK does not gate latching. A masked edge source still latches pending and requests once unmasked.
- Reset clears all state:
  - pending, mask, mode (all sources level) to 0.
  - Synchroniser and `p` flops to 0.
  - `o_int` to 0, `o_int_id` to 0.
- An edge source held high across reset re-triggers after reset, because `p` restarts at 0.

## Timing
- `o_rdata` has zero latency, like the asynchronous-read IMEM.
- `o_int`/`o_int_id` are registered one cycle after the active vector changes.
- With `INT_CTRL_SYNC_EN`: input rises before edge 1 → `s` high after edge 2 → edge pending set at edge 3 → `o_int` high after edge 4.
- Level mode with `INT_CTRL_SYNC_EN`: `o_int` high after edge 3.
- Without the macro, every latency above is one cycle shorter.
- Register write at edge k → `o_int` reflects it after edge k+1.
- A claim at edge k drops `o_int` after edge k+1 if no other source is active.

## Configuration
- `INT_CTRL_SYNC_EN`:
  - Defined: two-flop synchroniser per source ahead of `s`.
  - Undefined: single input register only, for sources already synchronous to `clk`.
  - Register map and priority behaviour are identical either way.

## Test plan
- Reset, then read all offsets → `0x0`. `o_int`=0, `o_int_id`=0.
- MASK=`0xFF`, MODE=`0x01`; pulse `i_irq[0]` for 1 cycle (macro defined) → PENDING=`0x01`, `o_int`=1 four edges after the rise, CLAIM=1. Claim read → PENDING=0, `o_int`=0 one edge later.
- MODE=0, MASK=`0x0C`; hold `i_irq[3:2]`=`2'b11` → `o_int_id`=3. Drop `i_irq[2]` → `o_int_id`=4. Drop both → `o_int_id`=0. W1C `0xFF` never changes PENDING.
- Edge source 5 masked, pulse → PENDING=`0x20`, `o_int`=0. Set MASK bit 5 → `o_int`=1 after one edge.
- W1C of bit 1 in the same cycle as a new rising edge on source 1 → bit 1 stays 1.
- Write MASK with `i_sel`=`4'b0001`, `i_wdata`=`0xFFFF_FFFF`, `NUM_SRC`=8 → MASK=`0xFF`. With `NUM_SRC`=4 → MASK=`0x0F`.
